// File: rtl/id_pkg.sv
// Shared decode constants for the instruction-decode stage.
// RV32I opcode, funct3 and funct7 fields plus the ALU operation encoding.
package id_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_SLL  = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_SLTU = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_OR   = 4'd9,
    ALU_AND  = 4'd10
  } alu_op_e;

endpackage

// File: rtl/id_imm_gen.sv
// Immediate extraction for the decode stage.
// Produces sign-extended I, U, J and B immediates from the raw word.
module id_imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm_i,
  output logic [XLEN-1:0] imm_u,
  output logic [XLEN-1:0] imm_j,
  output logic [XLEN-1:0] imm_b
);

  logic [31:0] i32;
  logic [31:0] u32;
  logic [31:0] j32;
  logic [31:0] b32;
  logic        unused_opc;

  assign i32 = {{20{inst[31]}}, inst[31:20]};
  assign u32 = {inst[31:12], 12'b0};
  assign j32 = {{12{inst[31]}}, inst[19:12],
                inst[20], inst[30:21], 1'b0};
  assign b32 = {{20{inst[31]}}, inst[7],
                inst[30:25], inst[11:8], 1'b0};

  assign imm_i = XLEN'($signed(i32));
  assign imm_u = XLEN'($signed(u32));
  assign imm_j = XLEN'($signed(j32));
  assign imm_b = XLEN'($signed(b32));

  // opcode bits carry no immediate content
  assign unused_opc = ^inst[6:0];

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: operand fetch with write-back bypass and a
// single-entry valid/ready pipeline register for the decoded bundle.
module id_stage
  import id_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RF_AW     = 5,
  parameter bit EN_BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst_i,
  input  logic [XLEN-1:0]  inst_addr_i,
  output logic [RF_AW-1:0] rs1_addr_o,
  output logic [RF_AW-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic             wb_wen_i,
  input  logic [RF_AW-1:0] wb_rd_i,
  input  logic [XLEN-1:0]  wb_data_i,
  input  logic             flush_i,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst_o,
  output logic [XLEN-1:0]  inst_addr_o,
  output logic [XLEN-1:0]  op1_o,
  output logic [XLEN-1:0]  op2_o,
  output logic [RF_AW-1:0] rd_addr_o,
  output logic             reg_wen_o,
  output logic [3:0]       alu_op_o,
  output logic             br_o,
  output logic             jmp_o,
  output logic             illegal_o
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rs1_f;
  logic [4:0] rs2_f;
  logic [4:0] rd_f;

  assign opcode = inst_i[6:0];
  assign f3     = inst_i[14:12];
  assign f7     = inst_i[31:25];
  assign rs1_f  = inst_i[19:15];
  assign rs2_f  = inst_i[24:20];
  assign rd_f   = inst_i[11:7];

  logic is_opimm;
  logic is_op;
  logic is_lui;
  logic is_auipc;
  logic is_jal;
  logic is_br;

  assign is_opimm = opcode == OPC_OP_IMM;
  assign is_op    = opcode == OPC_OP;
  assign is_lui   = opcode == OPC_LUI;
  assign is_auipc = opcode == OPC_AUIPC;
  assign is_jal   = opcode == OPC_JAL;
  assign is_br    = opcode == OPC_BRANCH;

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;
  logic [XLEN-1:0] imm_b;
  logic            unused_imm;

  id_imm_gen #(.XLEN(XLEN)) u_imm (
    .inst  (inst_i),
    .imm_i (imm_i),
    .imm_u (imm_u),
    .imm_j (imm_j),
    .imm_b (imm_b)
  );

  // jump/branch targets are resolved downstream from inst_o
  assign unused_imm = ^{imm_j, imm_b};

  // unused source fields read as x0 so the file sees no spurious reads
  assign rs1_addr_o = (is_opimm | is_op | is_br)
                    ? RF_AW'(rs1_f) : '0;
  assign rs2_addr_o = (is_op | is_br)
                    ? RF_AW'(rs2_f) : '0;

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

  assign rs1_val =
    (rs1_addr_o == '0) ? '0 :
    (EN_BYPASS && wb_wen_i && wb_rd_i == rs1_addr_o)
      ? wb_data_i : rs1_data_i;

  assign rs2_val =
    (rs2_addr_o == '0) ? '0 :
    (EN_BYPASS && wb_wen_i && wb_rd_i == rs2_addr_o)
      ? wb_data_i : rs2_data_i;

  logic             ok;
  alu_op_e          alu;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [RF_AW-1:0] rd;
  logic             wen;
  logic             br;
  logic             jmp;

  always_comb begin
    ok  = 1'b0;
    alu = ALU_NOP;
    a   = '0;
    b   = '0;
    rd  = '0;
    wen = 1'b0;
    br  = 1'b0;
    jmp = 1'b0;
    unique case (1'b1)
      is_opimm: begin
        ok  = 1'b1;
        a   = rs1_val;
        b   = imm_i;
        rd  = RF_AW'(rd_f);
        wen = 1'b1;
        unique case (f3)
          F3_ADD:  alu = ALU_ADD;
          F3_SLT:  alu = ALU_SLT;
          F3_SLTU: alu = ALU_SLTU;
          F3_XOR:  alu = ALU_XOR;
          F3_OR:   alu = ALU_OR;
          F3_AND:  alu = ALU_AND;
          F3_SLL: begin
            alu = ALU_SLL;
            b   = XLEN'(rs2_f);
            ok  = f7 == F7_BASE;
          end
          F3_SR: begin
            alu = f7[5] ? ALU_SRA : ALU_SRL;
            b   = XLEN'(rs2_f);
            ok  = (f7 == F7_BASE) || (f7 == F7_ALT);
          end
          default: ok = 1'b0;
        endcase
      end
      is_op: begin
        ok  = 1'b1;
        a   = rs1_val;
        b   = rs2_val;
        rd  = RF_AW'(rd_f);
        wen = 1'b1;
        unique case ({f7, f3})
          {F7_BASE, F3_ADD}:  alu = ALU_ADD;
          {F7_ALT,  F3_ADD}:  alu = ALU_SUB;
          {F7_BASE, F3_SLL}:  alu = ALU_SLL;
          {F7_BASE, F3_SLT}:  alu = ALU_SLT;
          {F7_BASE, F3_SLTU}: alu = ALU_SLTU;
          {F7_BASE, F3_XOR}:  alu = ALU_XOR;
          {F7_BASE, F3_SR}:   alu = ALU_SRL;
          {F7_ALT,  F3_SR}:   alu = ALU_SRA;
          {F7_BASE, F3_OR}:   alu = ALU_OR;
          {F7_BASE, F3_AND}:  alu = ALU_AND;
          default:            ok  = 1'b0;
        endcase
      end
      is_lui: begin
        ok  = 1'b1;
        alu = ALU_ADD;
        b   = imm_u;
        rd  = RF_AW'(rd_f);
        wen = 1'b1;
      end
      is_auipc: begin
        ok  = 1'b1;
        alu = ALU_ADD;
        a   = inst_addr_i;
        b   = imm_u;
        rd  = RF_AW'(rd_f);
        wen = 1'b1;
      end
      is_jal: begin
        ok  = 1'b1;
        alu = ALU_ADD;
        a   = inst_addr_i;
        b   = XLEN'(4);
        rd  = RF_AW'(rd_f);
        wen = 1'b1;
        jmp = 1'b1;
      end
      is_br: begin
        ok = 1'b1;
        a  = rs1_val;
        b  = rs2_val;
        br = 1'b1;
        unique case (f3)
          F3_BEQ, F3_BNE:   alu = ALU_SUB;
          F3_BLT, F3_BGE:   alu = ALU_SLT;
          F3_BLTU, F3_BGEU: alu = ALU_SLTU;
          default:          ok  = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      alu = ALU_NOP;
      a   = '0;
      b   = '0;
      rd  = '0;
      wen = 1'b0;
      br  = 1'b0;
      jmp = 1'b0;
    end
    if (rd == '0) wen = 1'b0;
  end

  logic take;

  assign in_ready = !out_valid || out_ready;
  assign take     = in_valid && in_ready;

  alu_op_e alu_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      inst_o      <= '0;
      inst_addr_o <= '0;
      op1_o       <= '0;
      op2_o       <= '0;
      rd_addr_o   <= '0;
      reg_wen_o   <= 1'b0;
      alu_q       <= ALU_NOP;
      br_o        <= 1'b0;
      jmp_o       <= 1'b0;
      illegal_o   <= 1'b0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (take) begin
      out_valid   <= 1'b1;
      inst_o      <= inst_i;
      inst_addr_o <= inst_addr_i;
      op1_o       <= a;
      op2_o       <= b;
      rd_addr_o   <= rd;
      reg_wen_o   <= wen;
      alu_q       <= alu;
      br_o        <= br;
      jmp_o       <= jmp;
      illegal_o   <= !ok;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign alu_op_o = alu_q;

endmodule
